// File: rtl/uart_tx_arb_if.sv
// Handshake bundle between the byte requesters, the round-robin arbiter
// and the shared uart_tx serializer.
interface uart_tx_arb_if #(
    parameter int N_REQ     = 4,
    parameter int PACK_SIZE = 8
);
    logic [N_REQ-1:0]           req_valid;
    logic [N_REQ*PACK_SIZE-1:0] req_data;
    logic [N_REQ-1:0]           req_ready;
    logic                       tx_byte_valid;
    logic [PACK_SIZE-1:0]       tx_byte_data;
    logic                       tx_active;
    logic                       tx_done;

    // Arbiter side: accepts requester bytes, drives the serializer.
    modport master (
        input  req_valid, req_data, tx_active, tx_done,
        output req_ready, tx_byte_valid, tx_byte_data
    );

    // Environment side: requesters plus the serializer.
    modport slave (
        output req_valid, req_data, tx_active, tx_done,
        input  req_ready, tx_byte_valid, tx_byte_data
    );
endinterface

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that shares one uart_tx serializer among N_REQ byte
// sources, with an optional idle gap after every frame.
module uart_tx_arb #(
    parameter int N_REQ      = 4,
    parameter int PACK_SIZE  = 8,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    uart_tx_arb_if.master            bus,
    output logic                     busy,
    output logic [$clog2(N_REQ)-1:0] cur_id
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [ID_W-1:0]  ID_MAX   = ID_W'(N_REQ - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_ISSUE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [ID_W-1:0]      last_id_q, last_id_d;
    logic                 tx_valid_q, tx_valid_d;
    logic [PACK_SIZE-1:0] tx_data_q, tx_data_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;

    logic                 rr_found;
    logic [ID_W-1:0]      rr_winner;
    logic [ID_W-1:0]      rr_idx;
    logic [N_REQ-1:0]     ready_vec;

    // Round-robin search: first valid requester after the last one served.
    always_comb begin
        rr_found  = 1'b0;
        rr_winner = '0;
        rr_idx    = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            rr_idx = ID_W'((int'(last_id_q) + off) % N_REQ);
            if (!rr_found && bus.req_valid[rr_idx]) begin
                rr_found  = 1'b1;
                rr_winner = rr_idx;
            end
        end
    end

    // Next-state and next-output computation for the sequencer.
    always_comb begin
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        last_id_d  = last_id_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        gap_cnt_d  = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                // A serializer still busy from before a reset blocks new grants.
                if (!bus.tx_active && rr_found) begin
                    cur_id_d = rr_winner;
                    state_d  = S_GRANT;
                end
            end
            S_GRANT: begin
                if (bus.req_valid[cur_id_q]) begin
                    tx_data_d  = bus.req_data[cur_id_q*PACK_SIZE +: PACK_SIZE];
                    tx_valid_d = 1'b1;
                    last_id_d  = cur_id_q;
                    state_d    = S_ISSUE;
                end else begin
                    // Requester withdrew: pointer stays so it keeps its priority.
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (bus.tx_active) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (bus.tx_done) begin
                    gap_cnt_d = '0;
                    state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset gives requester 0 first priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cur_id_q   <= '0;
            last_id_q  <= ID_MAX;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            last_id_q  <= last_id_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    // Ready is offered only to the granted requester, only during GRANT.
    always_comb begin
        ready_vec = '0;
        if (state_q == S_GRANT) begin
            ready_vec[cur_id_q] = 1'b1;
        end
    end

    assign bus.req_ready     = ready_vec;
    assign bus.tx_byte_valid = tx_valid_q;
    assign bus.tx_byte_data  = tx_data_q;
    assign busy              = (state_q != S_IDLE);
    assign cur_id            = cur_id_q;
endmodule
